bit_serial_add_ctrl: RTL and testbench

- Sequencer that time-shares a single 1-bit full-adder cell to add two WIDTH-bit operands, one bit per clock, LSB first.
- Small-area alternative to the ripple-carry adder. Used by the lab datapath wherever add latency is acceptable.
- Start/busy/done handshake. Result and carry-out are held stable until the next accepted start.

---
 rtl/serial_add_pkg.sv | 16 +
 rtl/serial_fa_cell.sv | 21 ++
 rtl/bit_serial_add_ctrl.sv | 140 ++++++++++++++
 tb/tb_bit_serial_add_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
// Holds the FSM state encoding and the bit-counter width helper.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int w);
        return (w < 1) ? 1 : $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder built from two half-adder stages.
// Ports: x, y, ci (inputs); s = sum, co = carry-out.
module serial_fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p1;
    logic g1;
    logic g2;

    assign p1 = x ^ y;
    assign g1 = x & y;
    assign s  = p1 ^ ci;
    assign g2 = p1 & ci;
    assign co = g1 | g2;

endmodule

// File: rtl/bit_serial_add_ctrl.sv
// Adds two WIDTH-bit operands one bit per clock through one shared
// full-adder cell, LSB first, with a start/busy/done handshake.
// Ports: clk, rst (sync, active-high), start, a, b, cin in;
//        busy, done, sum, cout out. With SERIAL_ADD_SUB_EN defined an
//        extra input sub selects a - b (cout=1 means no borrow).
module bit_serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sub_w;
    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] part_shift;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_w = sub;
`else
    assign sub_w = 1'b0;
`endif

    serial_fa_cell u_fa (
        .x  (a_q[0]),
        .y  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB, so after WIDTH shifts the first
    // bit computed sits at bit 0.
    if (WIDTH == 1) begin : g_w1
        assign part_shift = fa_s;
    end else begin : g_wn
        assign part_shift = {fa_s, part_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    // Subtract as a + ~b + 1.
                    b_d     = sub_w ? ~b : b;
                    carry_d = sub_w ? 1'b1 : cin;
                    part_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                part_d  = part_shift;
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    sum_d   = part_shift;
                    cout_d  = fa_co;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Self-checking bench for bit_serial_add_ctrl at WIDTH=8.
// Checks timing, hold behaviour, reset abort and random sums.
module tb_bit_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int total;
    int bad;
    int cyc;
    int done_cyc;
    int prev_done_cyc;

    logic [W-1:0] exp_sum;
    logic         exp_cout;

    bit_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands.
    task automatic model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input logic is,
                         output logic [W-1:0] rs, output logic rc);
        int unsigned t;
        if (is) begin
            rs = W'((ia - ib) % (1 << W));
            rc = (ia >= ib);
        end else begin
            t  = int'(ia) + int'(ib) + int'(ic);
            rs = W'(t % (1 << W));
            rc = (t >= (1 << W));
        end
    endtask

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ic, input logic is,
                          input bit noise, input bit chain);
        logic [W-1:0] rs;
        logic         rc;
        model(ia, ib, ic, is, rs, rc);
        a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < W; k++) begin
            chk("busy_run", busy, 1);
            chk("done_run", done, 0);
            chk("sum_hold", sum, exp_sum);
            chk("cout_hold", cout, exp_cout);
            if (noise) begin
                start = 1'($urandom);
                a     = W'($urandom);
                b     = W'($urandom);
                cin   = 1'($urandom);
                sub   = 1'($urandom);
            end
            tick;
        end
        start = 1'b0;
        exp_sum  = rs;
        exp_cout = rc;
        prev_done_cyc = done_cyc;
        done_cyc = cyc;
        chk("done_pulse", done, 1);
        chk("busy_done", busy, 0);
        chk("sum", sum, exp_sum);
        chk("cout", cout, exp_cout);
        if (!chain) begin
            tick;
            chk("done_low", done, 0);
            chk("busy_idle", busy, 0);
            chk("sum_idle", sum, exp_sum);
            chk("cout_idle", cout, exp_cout);
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        done_cyc = 0; prev_done_cyc = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        exp_sum = '0; exp_cout = 1'b0;
        tick; tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        rst = 1'b0;
        tick;

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0, 0);
        chk("plan1_sum", exp_sum, 8'h96);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 0);
        run_op(8'h00, 8'h00, 1'b1, 1'b0, 0, 0);
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 1, 0);

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0, 1);
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 0, 0);
        chk("b2b_gap", 32'(done_cyc - prev_done_cyc), 9);

        a = 8'h77; b = 8'h11; start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("abort_busy", busy, 1);
            tick;
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_sum = '0; exp_cout = 1'b0;
        chk("abort_busy0", busy, 0);
        chk("abort_done0", done, 0);
        chk("abort_sum0", sum, 0);
        chk("abort_cout0", cout, 0);
        for (int k = 0; k < 12; k++) begin
            tick;
            chk("abort_nodone", done, 0);
            chk("abort_idle", busy, 0);
        end

`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 0, 0);
        chk("sub1_sum", exp_sum, 8'h0F);
        run_op(8'h01, 8'h02, 1'b1, 1'b1, 0, 0);
        chk("sub2_sum", exp_sum, 8'hFF);
`endif

        for (int n = 0; n < 24; n++) begin
            logic is;
`ifdef SERIAL_ADD_SUB_EN
            is = 1'($urandom);
`else
            is = 1'b0;
`endif
            run_op(W'($urandom), W'($urandom), 1'($urandom), is,
                   bit'($urandom), bit'($urandom));
        end
        start = 1'b0;
        tick; tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
